otter_fetch_unit: RTL and testbench
===================================

// Module: otter_fetch_unit
// PURPOSE
//  Fetch stage sitting directly downstream of the PC register: takes current PC (PC DOUT),
//  requests the instruction from instruction memory over a req/ack handshake, latches it
//  into IR for decode, and drives the PC register's DIN/PC_WRITE (sequential PC+4 or redirect).
//  Single outstanding request; multi-cycle memory latency and decode backpressure tolerated.
// PARAMETERS
//  ADDR_W   32  address/PC width
//  DATA_W   32  instruction width
// PORTS
//  CLK         in   1       clock, all state updates on posedge
//  RESET       in   1       synchronous, active-high
//  PC_IN       in   ADDR_W  current PC (from PC DOUT)
//  PC_NEXT     out  ADDR_W  to PC DIN (combinational)
//  PC_WRITE    out  1       to PC PC_WRITE (combinational, single-cycle pulses)
//  REDIRECT    in   1       branch/jump/trap taken this cycle
//  REDIRECT_PC in   ADDR_W  redirect target
//  IMEM_REQ    out  1       registered; read request
//  IMEM_ADDR   out  ADDR_W  registered; held stable while IMEM_REQ=1
//  IMEM_ACK    in   1       read data valid this cycle (may coincide with first REQ cycle)
//  IMEM_RDATA  in   DATA_W  instruction word, sampled when IMEM_ACK=1
//  IR          out  DATA_W  latched instruction
//  IR_PC       out  ADDR_W  address IR was fetched from
//  IR_VALID    out  1       IR holds an unconsumed instruction
//  DEC_READY   in   1       decode accepts IR when IR_VALID&&DEC_READY
//  FETCH_FAULT out  1       misaligned PC (PC[1:0]!=0); held until redirect
//  FAULT_ADDR  out  ADDR_W  offending PC
// BEHAVIOUR
//  Reset: state IDLE; IMEM_REQ=0, IMEM_ADDR=0, IR=0, IR_PC=0, IR_VALID=0, FETCH_FAULT=0,
//   FAULT_ADDR=0; PC_WRITE=0 while RESET. RESET mid-request abandons it; ACK seen in IDLE ignored.
//  States: IDLE, WAIT, HOLD, DROP, FAULT.
//  IDLE: PC_IN aligned -> WAIT, IMEM_REQ<=1, IMEM_ADDR<=PC_IN; misaligned -> FAULT,
//   FAULT_ADDR<=PC_IN.
//  WAIT: REQ/ADDR held until ACK. On ACK: IR<=RDATA, IR_PC<=IMEM_ADDR, IR_VALID<=1,
//   IMEM_REQ<=0, PC_WRITE=1, PC_NEXT=IMEM_ADDR+4 (mod 2^ADDR_W, wraps) -> HOLD.
//  HOLD: IR, IR_PC stable. On accept: IR_VALID<=0 and same issue rule as IDLE on PC_IN
//   (-> WAIT or FAULT). No accept: stay, no PC_WRITE, IMEM_REQ=0.
//  DROP: request outstanding but stale; REQ held; on ACK data discarded, REQ<=0 -> IDLE.
//  FAULT: FETCH_FAULT=1, no requests; leaves only via REDIRECT.
//  REDIRECT (highest priority, any state except RESET): PC_WRITE=1, PC_NEXT=REDIRECT_PC,
//   IR_VALID<=0 (even if accepted same cycle), FETCH_FAULT<=0.
//   Next state: WAIT w/o ACK -> DROP; WAIT with ACK -> IDLE (data discarded, no +4 write);
//   DROP w/o ACK -> DROP; otherwise -> IDLE.
//  Latency: IDLE->REQ 1 cycle; ACK cycle -> IR_VALID next cycle; best throughput 1 instr/2 cycles.
//  Only one PC_WRITE per cycle; at most one outstanding request ever.
// STRUCTURE
//  Package otter_fetch_pkg: fetch_state_t enum {IDLE,WAIT,HOLD,DROP,FAULT}, INSTR_BYTES=4,
//   NOP_INSTR=32'h0000_0013 (optional IR fill for decode).
//  Single always_ff state/datapath + always_comb PC_NEXT/PC_WRITE; no sub-module needed.
// TESTING
//  Reset 2 cycles, PC_IN=0, ACK 1 cycle after REQ with RDATA=0x00500093 -> REQ ADDR=0; ACK cycle
//   PC_WRITE=1 PC_NEXT=4; next cycle IR=0x00500093, IR_PC=0, IR_VALID=1.
//  Hold DEC_READY=0 5 cycles in HOLD -> IR stable, IMEM_REQ=0, PC_WRITE=0; raise READY
//   (PC_IN=4) -> next cycle REQ=1, ADDR=4.
//  REDIRECT to 0x100 in WAIT, ACK 3 cycles later -> PC_WRITE/PC_NEXT=0x100 that cycle; REQ held
//   to ACK; IR_VALID stays 0; next REQ ADDR=0x100.
//  REDIRECT to 0x200 same cycle as ACK -> PC_NEXT=0x200 (not ADDR+4), IR_VALID stays 0, -> IDLE.
//  REDIRECT to 0x102 -> FETCH_FAULT=1, FAULT_ADDR=0x102, no REQ; REDIRECT 0x104 -> fault clears,
//   REQ ADDR=0x104.
//  RESET asserted in WAIT, ACK arrives after release while IDLE -> ignored, IR_VALID=0; fresh REQ
//   issued at PC_IN=0; PC_IN=0xFFFFFFFC fetch -> PC_NEXT wraps to 0.

Source files
------------

// File: rtl/otter_fetch_pkg.sv
// otter_fetch_pkg: shared fetch-stage types and constants
package otter_fetch_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, HOLD, DROP, FAULT} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/otter_fetch_unit_if.sv
// otter_fetch_unit_if: instruction-memory read request/acknowledge bus
interface otter_fetch_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic IMEM_REQ;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic IMEM_ACK;
  logic [DATA_W-1:0] IMEM_RDATA;
  modport master(output IMEM_REQ, IMEM_ADDR, input IMEM_ACK, IMEM_RDATA);
  modport slave(input IMEM_REQ, IMEM_ADDR, output IMEM_ACK, IMEM_RDATA);
endinterface

// File: rtl/otter_fetch_unit.sv
// otter_fetch_unit: fetches the instruction at PC into IR and steers the PC register
module otter_fetch_unit
  import otter_fetch_pkg::*;
#(parameter int ADDR_W = 32, parameter int DATA_W = 32) (
  input  logic CLK,
  input  logic RESET,
  input  logic [ADDR_W-1:0] PC_IN,
  output logic [ADDR_W-1:0] PC_NEXT,
  output logic PC_WRITE,
  input  logic REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  otter_fetch_unit_if.master imem,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_PC,
  output logic IR_VALID,
  input  logic DEC_READY,
  output logic FETCH_FAULT,
  output logic [ADDR_W-1:0] FAULT_ADDR
);
  fetch_state_t state;
  logic aligned, outstanding;
  assign aligned = PC_IN[1:0] == 2'b00;
  assign outstanding = state == WAIT || state == DROP;
  // PC register steering: redirect wins, otherwise advance past a completed live fetch
  always_comb begin
    PC_WRITE = !RESET && (REDIRECT || (state == WAIT && imem.IMEM_ACK));
    PC_NEXT = REDIRECT ? REDIRECT_PC : imem.IMEM_ADDR + ADDR_W'(INSTR_BYTES);
  end
  // fetch FSM with registered request, IR and fault outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      imem.IMEM_REQ <= 1'b0;
      imem.IMEM_ADDR <= '0;
      IR <= '0;
      IR_PC <= '0;
      IR_VALID <= 1'b0;
      FETCH_FAULT <= 1'b0;
      FAULT_ADDR <= '0;
    end else if (REDIRECT) begin
      IR_VALID <= 1'b0;
      FETCH_FAULT <= 1'b0;
      imem.IMEM_REQ <= outstanding && !imem.IMEM_ACK;
      state <= outstanding && !imem.IMEM_ACK ? DROP : IDLE;
    end else begin
      case (state)
        IDLE, HOLD: if (state == IDLE || (IR_VALID && DEC_READY)) begin
          IR_VALID <= 1'b0;
          if (aligned) begin
            imem.IMEM_REQ <= 1'b1;
            imem.IMEM_ADDR <= PC_IN;
            state <= WAIT;
          end else begin
            FETCH_FAULT <= 1'b1;
            FAULT_ADDR <= PC_IN;
            state <= FAULT;
          end
        end
        WAIT: if (imem.IMEM_ACK) begin
          IR <= imem.IMEM_RDATA;
          IR_PC <= imem.IMEM_ADDR;
          IR_VALID <= 1'b1;
          imem.IMEM_REQ <= 1'b0;
          state <= HOLD;
        end
        DROP: if (imem.IMEM_ACK) begin
          imem.IMEM_REQ <= 1'b0;
          state <= IDLE;
        end
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_otter_fetch_unit.sv
// tb_otter_fetch_unit: directed and randomized checks against a transaction-level fetch model
module tb_otter_fetch_unit;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [31:0] PC_IN, PC_NEXT, REDIRECT_PC, IR, IR_PC, FAULT_ADDR;
  logic PC_WRITE, REDIRECT, IR_VALID, DEC_READY, FETCH_FAULT;
  otter_fetch_unit_if bus();
  otter_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .PC_IN(PC_IN), .PC_NEXT(PC_NEXT), .PC_WRITE(PC_WRITE),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .imem(bus), .IR(IR), .IR_PC(IR_PC),
    .IR_VALID(IR_VALID), .DEC_READY(DEC_READY), .FETCH_FAULT(FETCH_FAULT), .FAULT_ADDR(FAULT_ADDR)
  );
  always #5 CLK = ~CLK;
  int total = 0;
  int bad = 0;
  logic busy, stale, ir_full, faulted, obs_pw;
  logic [31:0] m_addr, m_ir, m_ir_pc, m_fa, pc_reg, obs_pn;
  assign PC_IN = pc_reg;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    busy = 0; stale = 0; ir_full = 0; faulted = 0;
    m_addr = 0; m_ir = 0; m_ir_pc = 0; m_fa = 0;
  endtask
  task automatic step(input logic rst, input logic rd, input logic [31:0] rpc,
                      input logic ak, input logic [31:0] rdat, input logic rdy);
    logic epw;
    logic [31:0] epn;
    @(negedge CLK);
    RESET = rst; REDIRECT = rd; REDIRECT_PC = rpc;
    bus.IMEM_ACK = ak; bus.IMEM_RDATA = rdat; DEC_READY = rdy;
    #1;
    epw = !rst && (rd || (busy && !stale && ak));
    epn = rd ? rpc : m_addr + 32'd4;
    obs_pw = PC_WRITE;
    obs_pn = PC_NEXT;
    chk("pc_write", 32'(PC_WRITE), 32'(epw));
    if (epw) chk("pc_next", PC_NEXT, epn);
    chk("imem_req", 32'(bus.IMEM_REQ), 32'(busy));
    if (busy) chk("imem_addr", bus.IMEM_ADDR, m_addr);
    chk("ir_valid", 32'(IR_VALID), 32'(ir_full));
    chk("ir", IR, m_ir);
    chk("ir_pc", IR_PC, m_ir_pc);
    chk("fetch_fault", 32'(FETCH_FAULT), 32'(faulted));
    chk("fault_addr", FAULT_ADDR, m_fa);
    @(posedge CLK);
    #1;
    if (rst) model_reset();
    else if (rd) begin
      ir_full = 0;
      faulted = 0;
      if (busy && !ak) stale = 1;
      else begin busy = 0; stale = 0; end
    end else if (busy) begin
      if (ak) begin
        if (!stale) begin m_ir = rdat; m_ir_pc = m_addr; ir_full = 1; end
        busy = 0;
        stale = 0;
      end
    end else if (!faulted && (!ir_full || rdy)) begin
      ir_full = 0;
      if (pc_reg[1:0] == 2'b00) begin busy = 1; m_addr = pc_reg; end
      else begin faulted = 1; m_fa = pc_reg; end
    end
    if (epw) pc_reg = epn;
  endtask
  initial begin
    logic [31:0] rpc;
    REDIRECT = 0; REDIRECT_PC = 0; DEC_READY = 0; bus.IMEM_ACK = 0; bus.IMEM_RDATA = 0; pc_reg = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req", 32'(bus.IMEM_REQ), 0);
    chk("rst_addr", bus.IMEM_ADDR, 0);
    chk("rst_ir", IR, 0);
    chk("rst_ir_pc", IR_PC, 0);
    chk("rst_ir_valid", 32'(IR_VALID), 0);
    chk("rst_fault", 32'(FETCH_FAULT), 0);
    chk("rst_fault_addr", FAULT_ADDR, 0);
    chk("rst_pc_write", 32'(PC_WRITE), 0);
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("first_req", 32'(bus.IMEM_REQ), 1);
    chk("first_addr", bus.IMEM_ADDR, 0);
    step(0, 0, 0, 1, 32'h0050_0093, 0);
    chk("ack_pw", 32'(obs_pw), 1);
    chk("ack_pn", obs_pn, 32'h4);
    chk("ir_loaded", IR, 32'h0050_0093);
    chk("ir_pc_loaded", IR_PC, 0);
    chk("ir_valid_set", 32'(IR_VALID), 1);
    repeat (5) step(0, 0, 0, 0, $urandom, 0);
    chk("hold_ir", IR, 32'h0050_0093);
    step(0, 0, 0, 0, 0, 1);
    chk("accept_addr", bus.IMEM_ADDR, 32'h4);
    chk("accept_req", 32'(bus.IMEM_REQ), 1);
    step(0, 1, 32'h100, 0, 0, 0);
    chk("redir_wait_pn", obs_pn, 32'h100);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("drop_req_held", 32'(bus.IMEM_REQ), 1);
    step(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    chk("drop_no_valid", 32'(IR_VALID), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("redir_addr", bus.IMEM_ADDR, 32'h100);
    step(0, 1, 32'h200, 1, 32'h1234_5678, 0);
    chk("redir_ack_pn", obs_pn, 32'h200);
    chk("redir_ack_valid", 32'(IR_VALID), 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0013, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h102, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("fault_set", 32'(FETCH_FAULT), 1);
    chk("fault_addr_set", FAULT_ADDR, 32'h102);
    repeat (2) step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h104, 0, 0, 0);
    chk("fault_clear", 32'(FETCH_FAULT), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("post_fault_addr", bus.IMEM_ADDR, 32'h104);
    pc_reg = 0;
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hBAD0_BAD0, 0);
    chk("stray_ack_valid", 32'(IR_VALID), 0);
    chk("fresh_req_addr", bus.IMEM_ADDR, 0);
    step(0, 0, 0, 1, 32'h0000_0013, 0);
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0067, 0);
    chk("wrap_pn", obs_pn, 0);
    chk("wrap_ir_pc", IR_PC, 32'hFFFF_FFFC);
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom_range(0, 3) == 0 ? $urandom : $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, rpc,
           busy ? $urandom_range(0, 2) == 0 : $urandom_range(0, 19) == 0,
           $urandom, 1'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
